// File: rtl/signal_gen.sv
// Three-tone DDS test-signal source: three phase-accumulator / sine-lookup channels
// whose registered samples are summed into a 12-bit composite with a valid flag.
module signal_gen #(
    parameter logic [31:0] FWORD1 = 32'd85899346,
    parameter logic [31:0] FWORD2 = 32'd257698038,
    parameter logic [31:0] FWORD3 = 32'd429496730,
    parameter logic [9:0]  POFF1  = 10'd0,
    parameter logic [9:0]  POFF2  = 10'd0,
    parameter logic [9:0]  POFF3  = 10'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  s1,
    output logic [9:0]  s2,
    output logic [9:0]  s3,
    output logic [11:0] signal_out,
    output logic        out_valid
);

    localparam int  NCH = 3;
    localparam real PI  = 3.141592653589793;

    localparam logic [31:0] FWORD [NCH] = '{FWORD1, FWORD2, FWORD3};
    localparam logic [9:0]  POFF  [NCH] = '{POFF1, POFF2, POFF3};

    // Full-wave table evaluated at elaboration so every entry is exactly floor(512 + 511*sin).
    logic [9:0] sineLut [1024];

    for (genvar k = 0; k < 1024; k++) begin : g_lut
        localparam real ANGLE = 2.0 * PI * k / 1024.0;
        localparam int  VALUE = $rtoi($floor(512.0 + 511.0 * $sin(ANGLE)));
        assign sineLut[k] = 10'(VALUE);
    end

    logic [31:0]    accQ    [NCH];
    logic [31:0]    accD    [NCH];
    logic [9:0]     addrD   [NCH];
    logic [9:0]     sampleQ [NCH];
    logic [9:0]     sampleD [NCH];
    logic [NCH-1:0] validQ;
    logic [11:0]    sumQ;
    logic [11:0]    sumD;
    logic           outValidQ;

    // The lookup uses the accumulator value from before this edge's update.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            accD[i]    = accQ[i] + FWORD[i];
            addrD[i]   = accQ[i][31:22] + POFF[i];
            sampleD[i] = sineLut[addrD[i]];
        end
        sumD = 12'(sampleQ[0]) + 12'(sampleQ[1]) + 12'(sampleQ[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                accQ[i]    <= '0;
                sampleQ[i] <= '0;
            end
            validQ <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                accQ[i]    <= accD[i];
                sampleQ[i] <= sampleD[i];
            end
            validQ <= '1;
        end
    end

    // Sum stage trails the sample stage by one clock, so its valid follows the channel valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumQ      <= '0;
            outValidQ <= 1'b0;
        end else begin
            sumQ      <= sumD;
            outValidQ <= &validQ;
        end
    end

    assign s1         = sampleQ[0];
    assign s2         = sampleQ[1];
    assign s3         = sampleQ[2];
    assign signal_out = sumQ;
    assign out_valid  = outValidQ;

endmodule

// File: tb/tb_signal_gen.sv
// Directed bench for signal_gen: three instances (default tones, one-step sweep with
// quadrature offsets, and a zero tuning word) share one clock and reset.
module tb_signal_gen;

    localparam real PI = 3.141592653589793;
    localparam logic [31:0] STEP = 32'h0040_0000;
    localparam logic [31:0] FA [3] = '{32'd85899346, 32'd257698038, 32'd429496730};
    localparam int POFFB [3] = '{0, 256, 768};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [9:0]  aS1, aS2, aS3, bS1, bS2, bS3, cS1, cS2, cS3;
    logic [11:0] aSum, bSum, cSum;
    logic        aValid, bValid, cValid;

    int checks = 0;
    int failures = 0;
    int mism = 0;

    always #10 clk = ~clk;

    signal_gen dutA (
        .clk(clk), .rst_n(rst_n), .s1(aS1), .s2(aS2), .s3(aS3),
        .signal_out(aSum), .out_valid(aValid)
    );

    signal_gen #(
        .FWORD1(STEP), .FWORD2(STEP), .FWORD3(STEP),
        .POFF1(10'd0), .POFF2(10'd256), .POFF3(10'd768)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .s1(bS1), .s2(bS2), .s3(bS3),
        .signal_out(bSum), .out_valid(bValid)
    );

    signal_gen #(.FWORD1(32'd0)) dutC (
        .clk(clk), .rst_n(rst_n), .s1(cS1), .s2(cS2), .s3(cS3),
        .signal_out(cSum), .out_valid(cValid)
    );

    function automatic int lutModel(int k);
        int  kk;
        real r;
        kk = k & 1023;
        r  = 512.0 + 511.0 * $sin(2.0 * PI * kk / 1024.0);
        return $rtoi($floor(r));
    endfunction

    // Sample n of a default-tuned channel (n = 0 is the sample after E1).
    function automatic int sampleA(int ch, int n);
        logic [31:0] acc;
        acc = FA[ch] * 32'(n);
        return lutModel(int'(acc[31:22]));
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Release reset off-edge and return just after E1, sampling mid low phase.
    task automatic applyStimulus();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, " A s1"}, int'(aS1), 0);
        checkOutput({tag, " A s2"}, int'(aS2), 0);
        checkOutput({tag, " A s3"}, int'(aS3), 0);
        checkOutput({tag, " A sum"}, int'(aSum), 0);
        checkOutput({tag, " A valid"}, int'(aValid), 0);
        checkOutput({tag, " B sum"}, int'(bSum), 0);
        checkOutput({tag, " B valid"}, int'(bValid), 0);
        checkOutput({tag, " C s1"}, int'(cS1), 0);
    endtask

    // Counts deviations of every instance from the model at sample index n.
    task automatic compareCycle(input int n);
        int aObs [3];
        int bObs [3];
        int cObs [3];
        int expSum;
        aObs = '{int'(aS1), int'(aS2), int'(aS3)};
        bObs = '{int'(bS1), int'(bS2), int'(bS3)};
        cObs = '{int'(cS1), int'(cS2), int'(cS3)};
        for (int ch = 0; ch < 3; ch++) begin
            if (aObs[ch] != sampleA(ch, n)) mism++;
            if (bObs[ch] != lutModel(n + POFFB[ch])) mism++;
            if (ch == 0) begin
                if (cObs[ch] != 512) mism++;
            end else if (cObs[ch] != sampleA(ch, n)) mism++;
        end
        if (n >= 1) begin
            expSum = sampleA(0, n - 1) + sampleA(1, n - 1) + sampleA(2, n - 1);
            if (int'(aSum) != expSum) mism++;
            if (aSum < 12'd3 || aSum > 12'd3069) mism++;
            expSum = lutModel(n - 1) + lutModel(n - 1 + 256) + lutModel(n - 1 + 768);
            if (int'(bSum) != expSum) mism++;
            expSum = 512 + sampleA(1, n - 1) + sampleA(2, n - 1);
            if (int'(cSum) != expSum) mism++;
            if (aValid !== 1'b1 || bValid !== 1'b1 || cValid !== 1'b1) mism++;
        end
    endtask

    // Entered just after E1; leaves just after E2.
    task automatic checkStartup(input string tag);
        checkOutput({tag, " E1 A s1"}, int'(aS1), 512);
        checkOutput({tag, " E1 A s2"}, int'(aS2), 512);
        checkOutput({tag, " E1 A s3"}, int'(aS3), 512);
        checkOutput({tag, " E1 A sum"}, int'(aSum), 0);
        checkOutput({tag, " E1 A valid"}, int'(aValid), 0);
        checkOutput({tag, " E1 B s1"}, int'(bS1), 512);
        checkOutput({tag, " E1 B s2"}, int'(bS2), 1023);
        checkOutput({tag, " E1 B s3"}, int'(bS3), 1);
        checkOutput({tag, " E1 C s1"}, int'(cS1), 512);
        @(negedge clk);
        checkOutput({tag, " E2 A sum"}, int'(aSum), 1536);
        checkOutput({tag, " E2 A valid"}, int'(aValid), 1);
        checkOutput({tag, " E2 B sum"}, int'(bSum), 1536);
        checkOutput({tag, " E2 B s1"}, int'(bS1), 515);
        checkOutput({tag, " E2 B s2"}, int'(bS2), 1022);
        checkOutput({tag, " E2 B s3"}, int'(bS3), 1);
        checkOutput({tag, " E2 C s1"}, int'(cS1), 512);
        checkOutput({tag, " E2 C valid"}, int'(cValid), 1);
    endtask

    initial begin
        $display("[TB] holding reset for 200 ns");
        #100;
        checkZero("in reset");
        #100;
        applyStimulus();
        checkStartup("powerup");

        mism = 0;
        for (int n = 2; n <= 10000; n++) begin
            @(negedge clk);
            compareCycle(n);
            if (n == 256)  checkOutput("B s1 sample 256", int'(bS1), 1023);
            if (n == 512)  checkOutput("B s1 sample 512", int'(bS1), 512);
            if (n == 768)  checkOutput("B s1 sample 768", int'(bS1), 1);
            if (n == 1024) checkOutput("B s1 sample 1024 wrap", int'(bS1), 512);
            if (n == 1024) checkOutput("B s2 sample 1024 wrap", int'(bS2), 1023);
        end
        checkOutput("long run model deviations", mism, 0);

        $display("[TB] asynchronous reset pulse mid-run");
        @(negedge clk);
        #3 rst_n = 1'b0;
        #4;
        checkZero("mid-run pulse");
        applyStimulus();
        checkStartup("restart");
        mism = 0;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            compareCycle(n);
        end
        checkOutput("restart sequence deviations", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
